// File: rtl/hsv_pwm_cycler.sv
// hsv_pwm_cycler: hue-wheel PWM driver with frame-aligned duty shadows and per-channel phase offsets.
// Defining HSV_PWM_BRIGHTNESS_EN adds an 8-bit global brightness input that scales every duty.
module hsv_pwm_cycler #(
    parameter int PWM_PERIOD   = 1200,
    parameter int N_CH         = 3,
    parameter int SEXT_STEPS   = 100,
    parameter int STEP_PERIODS = 20,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            hold,
    input  logic                            dir,
`ifdef HSV_PWM_BRIGHTNESS_EN
    input  logic [7:0]                      brightness,
`endif
    output logic [N_CH-1:0]                 pwm_out,
    output logic                            frame_tick,
    output logic [$clog2(6*SEXT_STEPS)-1:0] hue_pos
);
    localparam int HUE_LEN  = 6 * SEXT_STEPS;
    localparam int DUTY_INC = PWM_PERIOD / SEXT_STEPS;
    localparam int OFFSET   = HUE_LEN / N_CH;
    localparam int HW       = $clog2(HUE_LEN);
    localparam int PW       = HW + 1;
    localparam int CW       = $clog2(PWM_PERIOD + 1);
    localparam int SW       = $clog2(STEP_PERIODS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] step_q, step_d;
    logic [HW-1:0] hue_q, hue_d;
    logic          first_q;
    logic          wrap, adv;

    assign wrap       = cnt_q == CW'(PWM_PERIOD - 1);
    assign adv        = wrap && !hold && step_q == SW'(STEP_PERIODS - 1);
    // the boundary closing the first frame after reset still loads and steps, it is just not announced
    assign frame_tick = wrap && !first_q;
    assign hue_pos    = hue_q;

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        step_d = (wrap && !hold) ? (adv ? '0 : step_q + SW'(1)) : step_q;
        hue_d  = !adv ? hue_q
               : dir  ? (hue_q == '0 ? HW'(HUE_LEN - 1) : hue_q - HW'(1))
               :        (hue_q == HW'(HUE_LEN - 1) ? '0 : hue_q + HW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            step_q  <= '0;
            hue_q   <= '0;
            first_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            hue_q   <= hue_d;
            first_q <= first_q && !wrap;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [PW-1:0] sum, pos, f;
        logic [2:0]    s;
        logic [CW-1:0] ramp, duty, load, shadow_q, shadow_d;

        always_comb begin
            sum  = PW'(hue_q) + PW'(HUE_LEN - k * OFFSET);
            pos  = sum >= PW'(HUE_LEN) ? sum - PW'(HUE_LEN) : sum;
            s    = pos >= PW'(5 * SEXT_STEPS) ? 3'd5
                 : pos >= PW'(4 * SEXT_STEPS) ? 3'd4
                 : pos >= PW'(3 * SEXT_STEPS) ? 3'd3
                 : pos >= PW'(2 * SEXT_STEPS) ? 3'd2
                 : pos >= PW'(SEXT_STEPS)     ? 3'd1
                 :                              3'd0;
            f    = pos - PW'(32'(s) * SEXT_STEPS);
            ramp = CW'(32'(f) * DUTY_INC);
            duty = (s == 3'd0 || s == 3'd5) ? CW'(PWM_PERIOD)
                 : s == 3'd1                ? CW'(PWM_PERIOD) - ramp
                 : s == 3'd4                ? ramp
                 :                            '0;
        end

`ifdef HSV_PWM_BRIGHTNESS_EN
        logic [CW+8:0] prod;
        assign prod = (CW+9)'(duty) * (CW+9)'({1'b0, brightness} + 9'd1);
        assign load = CW'(prod >> 8);
`else
        assign load = duty;
`endif

        assign shadow_d   = wrap ? load : shadow_q;
        assign pwm_out[k] = (cnt_q < shadow_q) ^ ACTIVE_LOW;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) shadow_q <= '0;
            else       shadow_q <= shadow_d;
        end
    end
endmodule
